arc4_pt_checker: RTL and testbench
==================================

Name: arc4_pt_checker

Overview:
- Reads the plaintext memory after the ARC4 PRGA decryption pass has written it, and decides whether the decrypted message is printable ASCII.
- The PT memory is length-prefixed: PT[0] is the length, PT[1..len] are the message bytes.
- Sits beside the PRGA in the key-search loop. The cracking controller starts it with en/rdy and uses ok to accept or reject a candidate key.
- Read-only on PT memory; it never writes.

Parameters:
- CHAR_LO, 8'h20, lowest printable byte (inclusive)
- CHAR_HI, 8'h7E, highest printable byte (inclusive)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  start request; sampled only while rdy=1
- rdy  out  1  1 = idle, and result outputs are valid
- pt_addr  out  8  PT memory read address
- pt_rddata  in  8  PT memory read data; synchronous RAM, 1-cycle latency
- ok  out  1  1 = every message byte lies in [CHAR_LO, CHAR_HI]
- bad_idx  out  8  index of the first failing byte; 0 when ok=1
- bad_byte  out  8  value of the first failing byte; 0 when ok=1

Behaviour:
- Reset values: rdy=1, ok=0, bad_idx=0, bad_byte=0, pt_addr=0, state=IDLE.
- Reset asserted mid-operation aborts immediately to these values. No partial result is retained.
- Handshake:
  - en is accepted at a rising edge where rdy=1 and en=1 (the acceptance edge).
  - rdy goes 0 on the next cycle. ok, bad_idx and bad_byte clear to 0 at the acceptance edge.
  - en while rdy=0 is ignored. A start is not queued.
  - Holding en high while rdy=1 launches back-to-back checks.
- Memory timing: the address driven in cycle N is captured from pt_rddata at the end of cycle N+1.
- pt_addr is 0 in every state except RD_BYTE and CHK_BYTE. In CHK_BYTE it holds k.
- State machine (one cycle per state):
  - IDLE: rdy=1. On en, go to RD_LEN.
  - RD_LEN: pt_addr=0. Go to LAT_LEN.
  - LAT_LEN: len <= pt_rddata; k <= 1. If pt_rddata==0, go to FINISH_OK, else go to RD_BYTE.
  - RD_BYTE: pt_addr=k. Go to CHK_BYTE.
  - CHK_BYTE, byte in range:
    - If k==len, go to FINISH_OK.
    - Otherwise k <= k+1 and go to RD_BYTE.
  - CHK_BYTE, byte out of range: capture bad_idx<=k and bad_byte<=pt_rddata, then go to FINISH_BAD (early abort).
  - FINISH_OK: ok<=1, bad_idx<=0, bad_byte<=0. Go to IDLE.
  - FINISH_BAD: ok<=0. Go to IDLE.
- Range test is unsigned: CHAR_LO <= byte <= CHAR_HI. Both bounds are inclusive.
- k is 8 bits. Termination compares k==len before any increment, so len=255 ends at k=255 without wrap.
- Latency, counted from the acceptance edge to the cycle rdy reads 1:
  - all bytes pass: 3+2*len cycles (len=0 gives 3)
  - first failure at index k: 3+2*k cycles
- Outputs are stable while rdy=1 and change only after the next acceptance edge or reset.

Optional Feature:
- Macro: ARC4_PTCHK_FULL_SCAN_EN.
- Defined:
  - Adds output port bad_count (8 bits), reset value 0 and cleared at the acceptance edge.
  - A failing byte does not abort the scan. bad_idx and bad_byte still record the first failure only.
  - bad_count increments once per out-of-range byte.
  - The scan always runs to k==len, so latency is 3+2*len.
  - ok = (bad_count==0) at FINISH.
- Undefined: early-abort behaviour exactly as above, and the bad_count port is absent.

Test Plan:
- Reset then idle: rdy=1, ok=0, bad_idx=0, pt_addr=0. en pulse with PT={0} -> rdy=1 after 3 cycles, ok=1, bad_idx=0.
- PT={5,"HELLO"} -> rdy back after 13 cycles, ok=1, bad_idx=0, bad_byte=0.
- PT={4,0x41,0x1F,0x42,0x7F} -> abort: rdy after 7 cycles, ok=0, bad_idx=2, bad_byte=0x1F. With ARC4_PTCHK_FULL_SCAN_EN: 11 cycles, bad_idx=2, bad_count=2.
- Boundaries: PT={3,0x20,0x7E,0x7E} -> ok=1. PT={1,0x80} -> ok=0, bad_byte=0x80. PT={255, 255 x 0x61} -> ok=1 after 513 cycles, no addr wrap past 0xFF.
- en toggled while rdy=0 -> ignored, result unchanged. en held high -> second check starts at the edge rdy=1 is seen, outputs cleared.
- rst_n dropped mid-scan at k=3 -> immediate rdy=1, ok=0, bad_idx=0, pt_addr=0. Next en runs a clean full check.

Source files
------------

// File: rtl/arc4_pt_checker.sv
// arc4_pt_checker
// Scans the length-prefixed plaintext memory written by the ARC4 PRGA pass
// and reports whether every message byte is printable ASCII.
// PT[0] holds the message length, PT[1..len] hold the message bytes.
// The memory is read-only from this block; reads have one cycle of latency.
// Optional build macro ARC4_PTCHK_FULL_SCAN_EN: scan every byte instead of
// aborting on the first failure, and report the failure count on bad_count.
module arc4_pt_checker #(
   parameter logic [7:0] CHAR_LO = 8'h20,
   parameter logic [7:0] CHAR_HI = 8'h7E
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic       ok,
   output logic [7:0] bad_idx,
   output logic [7:0] bad_byte
`ifdef ARC4_PTCHK_FULL_SCAN_EN
   ,
   output logic [7:0] bad_count
`endif
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      RD_LEN     = 3'd1,
      LAT_LEN    = 3'd2,
      RD_BYTE    = 3'd3,
      CHK_BYTE   = 3'd4,
      FINISH_OK  = 3'd5,
      FINISH_BAD = 3'd6
   } state_t;

   // Unsigned inclusive printable-range test.
   function automatic logic in_range_f(input logic [7:0] b);
      return (b >= CHAR_LO) && (b <= CHAR_HI);
   endfunction

   state_t     state_r, state_s;
   logic [7:0] k_r, k_s;
   logic [7:0] len_r, len_s;
   logic       rdy_r, rdy_s;
   logic       ok_r, ok_s;
   logic [7:0] bad_idx_r, bad_idx_s;
   logic [7:0] bad_byte_r, bad_byte_s;
   logic [7:0] pt_addr_r, pt_addr_s;
   logic       byte_ok_s;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
   logic [7:0] bad_count_r, bad_count_s;
`endif

   // Next-state and next-output computation for the scan sequencer.
   always_comb begin
      state_s    = state_r;
      k_s        = k_r;
      len_s      = len_r;
      ok_s       = ok_r;
      bad_idx_s  = bad_idx_r;
      bad_byte_s = bad_byte_r;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
      bad_count_s = bad_count_r;
`endif
      byte_ok_s  = in_range_f(pt_rddata);

      case (state_r)
         IDLE: begin
            if (en) begin
               // Acceptance edge: results from the previous check are dropped.
               state_s    = RD_LEN;
               ok_s       = 1'b0;
               bad_idx_s  = 8'h00;
               bad_byte_s = 8'h00;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
               bad_count_s = 8'h00;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         RD_LEN: begin
            state_s = LAT_LEN;
         end
         LAT_LEN: begin
            len_s = pt_rddata;
            k_s   = 8'd1;
            if (pt_rddata == 8'h00) begin
               state_s = FINISH_OK;
            end else begin
               state_s = RD_BYTE;
            end
         end
         RD_BYTE: begin
            state_s = CHK_BYTE;
         end
         CHK_BYTE: begin
`ifdef ARC4_PTCHK_FULL_SCAN_EN
            if (!byte_ok_s) begin
               bad_count_s = bad_count_r + 8'd1;
               if (bad_count_r == 8'h00) begin
                  bad_idx_s  = k_r;
                  bad_byte_s = pt_rddata;
               end else begin
                  bad_idx_s  = bad_idx_r;
                  bad_byte_s = bad_byte_r;
               end
            end else begin
               bad_count_s = bad_count_r;
            end
            // Compare before incrementing so len=255 finishes at k=255.
            if (k_r == len_r) begin
               if (bad_count_s == 8'h00) begin
                  state_s = FINISH_OK;
               end else begin
                  state_s = FINISH_BAD;
               end
            end else begin
               k_s     = k_r + 8'd1;
               state_s = RD_BYTE;
            end
`else
            if (!byte_ok_s) begin
               bad_idx_s  = k_r;
               bad_byte_s = pt_rddata;
               state_s    = FINISH_BAD;
            end else if (k_r == len_r) begin
               state_s = FINISH_OK;
            end else begin
               k_s     = k_r + 8'd1;
               state_s = RD_BYTE;
            end
`endif
         end
         FINISH_OK: begin
            ok_s       = 1'b1;
            bad_idx_s  = 8'h00;
            bad_byte_s = 8'h00;
            state_s    = IDLE;
         end
         FINISH_BAD: begin
            ok_s    = 1'b0;
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // Registered outputs are derived from the state being entered.
      rdy_s = (state_s == IDLE);
      if ((state_s == RD_BYTE) || (state_s == CHK_BYTE)) begin
         pt_addr_s = k_s;
      end else begin
         pt_addr_s = 8'h00;
      end
   end

   // State, counters and registered outputs; reset aborts any scan in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         k_r        <= 8'h00;
         len_r      <= 8'h00;
         rdy_r      <= 1'b1;
         ok_r       <= 1'b0;
         bad_idx_r  <= 8'h00;
         bad_byte_r <= 8'h00;
         pt_addr_r  <= 8'h00;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
         bad_count_r <= 8'h00;
`endif
      end else begin
         state_r    <= state_s;
         k_r        <= k_s;
         len_r      <= len_s;
         rdy_r      <= rdy_s;
         ok_r       <= ok_s;
         bad_idx_r  <= bad_idx_s;
         bad_byte_r <= bad_byte_s;
         pt_addr_r  <= pt_addr_s;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
         bad_count_r <= bad_count_s;
`endif
      end
   end

   assign rdy      = rdy_r;
   assign ok       = ok_r;
   assign bad_idx  = bad_idx_r;
   assign bad_byte = bad_byte_r;
   assign pt_addr  = pt_addr_r;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
   assign bad_count = bad_count_r;
`endif

endmodule

// File: tb/tb_arc4_pt_checker.sv
// Testbench for arc4_pt_checker: directed PT images, a behavioural result
// model, per-cycle idle-output comparison and literal latency/result checks.
`timescale 1ns/1ps
module tb_arc4_pt_checker;

   localparam logic [7:0] LO = 8'h20;
   localparam logic [7:0] HI = 8'h7E;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       rdy;
   logic [7:0] pt_addr;
   logic [7:0] pt_rddata;
   logic       ok;
   logic [7:0] bad_idx;
   logic [7:0] bad_byte;
`ifdef ARC4_PTCHK_FULL_SCAN_EN
   logic [7:0] bad_count;
`endif

   logic [7:0] mem [0:255];
   logic [7:0] pt_q [$];

   int n_chk = 0;
   int n_fail = 0;

   logic       exp_ok = 1'b0;
   logic [7:0] exp_idx = 8'h00;
   logic [7:0] exp_byte = 8'h00;
   logic [7:0] exp_cnt = 8'h00;

   arc4_pt_checker dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .rdy(rdy),
      .pt_addr(pt_addr),
      .pt_rddata(pt_rddata),
      .ok(ok),
      .bad_idx(bad_idx),
      .bad_byte(bad_byte)
`ifdef ARC4_PTCHK_FULL_SCAN_EN
      ,
      .bad_count(bad_count)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous PT RAM with one cycle of read latency.
   always @(posedge clk) pt_rddata <= mem[pt_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Result model straight from the rules: scan message, first failure wins.
   task automatic model(output logic m_ok, output logic [7:0] m_idx, output logic [7:0] m_byte,
                        output logic [7:0] m_cnt, output int m_lat);
      int len;
      len = int'(mem[0]);
      m_ok = 1'b1; m_idx = 8'h00; m_byte = 8'h00; m_cnt = 8'h00;
      m_lat = 3 + 2 * len;
      for (int i = 1; i <= len; i++) begin
         if ((mem[i] < LO) || (mem[i] > HI)) begin
            if (m_cnt == 8'h00) begin
               m_idx  = 8'(i);
               m_byte = mem[i];
`ifndef ARC4_PTCHK_FULL_SCAN_EN
               m_lat = 3 + 2 * i;
`endif
            end
            m_cnt = m_cnt + 8'd1;
         end
      end
      m_ok = (m_cnt == 8'h00);
   endtask

   task automatic load();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      foreach (pt_q[i]) mem[i] = pt_q[i];
   endtask

   // Launch one check, measure latency and compare against literal expectations.
   task automatic run(input string nm, input int e_lat, input logic e_ok, input logic [7:0] e_idx,
                      input logic [7:0] e_byte, input logic [7:0] e_cnt, input bit toggle);
      logic m_ok; logic [7:0] m_idx, m_byte, m_cnt; int m_lat; int cyc;
      @(negedge clk);
      load();
      model(m_ok, m_idx, m_byte, m_cnt, m_lat);
      chk({nm, "_model_cnt"}, 32'(m_cnt), 32'(e_cnt));
      chk({nm, "_rdy_pre"}, 32'(rdy), 32'd1);
      en = 1'b1;
      @(posedge clk);
      exp_ok = m_ok; exp_idx = m_idx; exp_byte = m_byte; exp_cnt = m_cnt;
      #1;
      en = 1'b0;
      chk({nm, "_rdy_drop"}, 32'(rdy), 32'd0);
      chk({nm, "_ok_clr"}, 32'(ok), 32'd0);
      cyc = 1;
      while (cyc < 600) begin
         @(posedge clk);
         #1;
         if (rdy) break;
         cyc++;
         if (toggle) en = ~en;
      end
      en = 1'b0;
      chk({nm, "_lat"}, 32'(cyc), 32'(e_lat));
      chk({nm, "_lat_model"}, 32'(cyc), 32'(m_lat));
      chk({nm, "_ok"}, 32'(ok), 32'(e_ok));
      chk({nm, "_idx"}, 32'(bad_idx), 32'(e_idx));
      chk({nm, "_byte"}, 32'(bad_byte), 32'(e_byte));
`ifdef ARC4_PTCHK_FULL_SCAN_EN
      chk({nm, "_cnt"}, 32'(bad_count), 32'(e_cnt));
`endif
   endtask

   // Every idle cycle the outputs must equal the model's last result.
   always @(negedge clk) begin
      if (rst_n && rdy) begin
         chk("idle_ok", 32'(ok), 32'(exp_ok));
         chk("idle_idx", 32'(bad_idx), 32'(exp_idx));
         chk("idle_byte", 32'(bad_byte), 32'(exp_byte));
         chk("idle_addr", 32'(pt_addr), 32'd0);
`ifdef ARC4_PTCHK_FULL_SCAN_EN
         chk("idle_cnt", 32'(bad_count), 32'(exp_cnt));
`endif
      end else if (rst_n) begin
         chk("addr_bound", 32'(pt_addr <= mem[0]), 32'd1);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      #23;
      chk("rst_rdy", 32'(rdy), 32'd1);
      chk("rst_ok", 32'(ok), 32'd0);
      chk("rst_idx", 32'(bad_idx), 32'd0);
      chk("rst_addr", 32'(pt_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      pt_q = '{8'd0};
      run("len0", 3, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      pt_q = '{8'd5, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      run("hello", 13, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      pt_q = '{8'd4, 8'h41, 8'h1F, 8'h42, 8'h7F};
`ifdef ARC4_PTCHK_FULL_SCAN_EN
      run("abort", 11, 1'b0, 8'd2, 8'h1F, 8'd2, 1'b0);
`else
      run("abort", 7, 1'b0, 8'd2, 8'h1F, 8'd2, 1'b0);
`endif
      pt_q = '{8'd3, 8'h20, 8'h7E, 8'h7E};
      run("edges", 9, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      pt_q = '{8'd1, 8'h80};
      run("hi80", 5, 1'b0, 8'd1, 8'h80, 8'd1, 1'b0);
      pt_q = '{8'd2, 8'h21, 8'h7F};
      run("x7f", 7, 1'b0, 8'd2, 8'h7F, 8'd1, 1'b0);
      pt_q.delete();
      pt_q.push_back(8'd255);
      for (int i = 0; i < 255; i++) pt_q.push_back(8'h61);
      run("len255", 513, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      pt_q = '{8'd2, 8'h41, 8'h10};
      run("toggle", 7, 1'b0, 8'd2, 8'h10, 8'd1, 1'b1);

      // en held high: a second check launches on the first idle edge.
      pt_q = '{8'd0};
      @(negedge clk);
      load();
      en = 1'b1;
      @(posedge clk);
      exp_ok = 1'b1; exp_idx = 8'h00; exp_byte = 8'h00; exp_cnt = 8'h00;
      cyc = 1;
      while (cyc < 50) begin
         @(posedge clk);
         #1;
         if (rdy) break;
         cyc++;
      end
      chk("held_lat1", 32'(cyc), 32'd3);
      @(posedge clk);
      #1;
      chk("held_restart_rdy", 32'(rdy), 32'd0);
      chk("held_restart_ok", 32'(ok), 32'd0);
      en = 1'b0;
      cyc = 1;
      while (cyc < 50) begin
         @(posedge clk);
         #1;
         if (rdy) break;
         cyc++;
      end
      chk("held_lat2", 32'(cyc), 32'd3);
      chk("held_ok2", 32'(ok), 32'd1);

      // Reset in the middle of a scan, once the reader has reached k=3.
      pt_q = '{8'd5, 8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
      @(negedge clk);
      load();
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      cyc = 0;
      while ((pt_addr != 8'd3) && (cyc < 50)) begin
         @(negedge clk);
         cyc++;
      end
      chk("mid_reach_k3", 32'(pt_addr), 32'd3);
      rst_n = 1'b0;
      exp_ok = 1'b0; exp_idx = 8'h00; exp_byte = 8'h00; exp_cnt = 8'h00;
      #1;
      chk("mid_rst_rdy", 32'(rdy), 32'd1);
      chk("mid_rst_ok", 32'(ok), 32'd0);
      chk("mid_rst_idx", 32'(bad_idx), 32'd0);
      chk("mid_rst_addr", 32'(pt_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pt_q = '{8'd3, 8'h61, 8'h62, 8'h63};
      run("after_rst", 9, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
